iir_decimator: RTL and testbench
================================

// Module: iir_decimator
// PURPOSE
//   Downstream consumer of the IIR filter output y. Takes one 12-bit sample per in_valid strobe,
//   averages non-overlapping windows of N = 2**LOG2N samples (boxcar decimate-by-N), and queues
//   the results in a DEPTH-entry FIFO with a valid/ready output handshake.
//   Also reports a sticky overflow flag when a result is dropped because the FIFO is full.
// PARAMETERS
//   DW     12  sample width; matches the IIR y output; unsigned
//   LOG2N  2   log2 of the decimation factor (N=4); legal values 1..4
//   DEPTH  4   FIFO entries; power of two, 2..16
// PORTS
//   clk        in   1        system clock; all flops on posedge
//   rst        in   1        reset; asynchronous, active-low (rst==0 resets)
//   in_valid   in   1        one-cycle strobe: in_data holds a new sample this cycle
//   in_data    in   DW       IIR output sample, unsigned
//   flush      in   1        synchronous; discards the partial window (FIFO is untouched)
//   out_valid  out  1        FIFO not empty
//   out_ready  in   1        consumer accepts out_data when out_valid&&out_ready
//   out_data   out  DW       head of FIFO (window average)
//   ovf        out  1        sticky: a result was dropped on full FIFO
//   ovf_clr    in   1        synchronous clear of ovf
//   level      out  log2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//   Reset (rst low, async): FSM=S_IDLE, acc=0, cnt=0, FIFO empty. Outputs: out_valid=0,
//     out_data=0, ovf=0, level=0. Asserting reset mid-window or mid-push loses all data.
//   Accumulator acc is DW+LOG2N bits wide and never overflows. cnt is LOG2N bits.
//   FSM:
//     S_IDLE: in_valid -> acc<=in_data, cnt<=1, go to S_ACC
//     S_ACC : in_valid && cnt!=N-1 -> acc<=acc+in_data, cnt<=cnt+1
//             in_valid && cnt==N-1 -> res<=(acc+in_data)>>LOG2N (truncate), go to S_PUSH
//     S_PUSH: one cycle; writes res to FIFO (or drops it). in_valid in this cycle starts the
//             next window: acc<=in_data, cnt<=1, go to S_ACC. Otherwise go to S_IDLE.
//   flush (any state): acc<=0, cnt<=0, go to S_IDLE. It has priority over in_valid that cycle.
//     A push already in S_PUSH still completes.
//   Latency: if the last sample of a window is strobed in cycle t, S_PUSH is cycle t+1 and
//     out_valid=1 in cycle t+2 (FIFO previously empty).
//   FIFO: pointers wrap modulo DEPTH; out_data is registered head (first-word fall-through).
//     Pop when out_valid&&out_ready. Push in S_PUSH if level<DEPTH, or if level==DEPTH and a
//     pop occurs the same cycle; in that case level is unchanged.
//     Push into a full FIFO with no pop: res is dropped, FIFO is unchanged, ovf<=1.
//     Push and pop on an empty FIFO cannot coincide (out_valid=0).
//     out_data holds its last value while out_valid=0.
//   ovf: set has priority over ovf_clr in the same cycle.
//   in_valid is never back-to-back from the IIR divided clock. The block still accepts
//     consecutive-cycle strobes with no sample loss.
// TESTING
//   1 rst low mid-window with 2 samples accumulated -> out_valid=0, level=0, ovf=0 immediately
//     (asynchronous); next 4 samples form a clean window.
//   2 N=4, strobe 10,20,30,41 with out_ready=1 -> out_data=25 (101>>2), out_valid at t+2, popped.
//   3 strobe 4095 x4 -> out_data=4095 (acc=16380, no wrap); 3 x 3 -> 3, truncation check for 1,1,1,2 -> 1.
//   4 out_ready=0, push 5 windows -> level=4, 5th dropped, ovf=1; ovf_clr -> ovf=0; drain
//     yields windows 1..4 in order.
//   5 FIFO full, S_PUSH coinciding with out_ready=1 -> no drop, ovf stays 0, level stays 4.
//   6 2 samples, flush, then 4 samples of 8 -> single result 8; window 8 strobed back-to-back
//     through S_PUSH -> two correct results.

Source files
------------

// File: rtl/iir_decimator_if.sv
// Sample-in / window-average-out handshake bundle for iir_decimator.
// The master side feeds samples and consumes averages; the slave side is the decimator.
interface iir_decimator_if #(
  parameter int DW    = 12,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic [DW-1:0]            in_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [DW-1:0]            out_data;
  logic                     ovf;
  logic                     ovf_clr;
  logic [$clog2(DEPTH):0]   level;

  modport master (
    output in_valid, in_data, flush, out_ready, ovf_clr,
    input  out_valid, out_data, ovf, level
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready, ovf_clr,
    output out_valid, out_data, ovf, level
  );
endinterface

// File: rtl/iir_decimator.sv
// Boxcar decimate-by-2**LOG2N of unsigned IIR samples, results queued in a DEPTH-entry
// first-word-fall-through FIFO with a sticky overflow flag for dropped results.
module iir_decimator #(
  parameter int DW    = 12,
  parameter int LOG2N = 2,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  iir_decimator_if.slave  bus
);
  localparam int SW = DW + LOG2N;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_PUSH = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     acc_q, acc_d, sum_s;
  logic [LOG2N-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     res_q, res_d;

  logic [DW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_valid_q;
  logic              ovf_q, ovf_d;
  logic              pop_s, push_s, drop_s;

  assign sum_s = acc_q + SW'(bus.in_data);

  // Window FSM state and accumulator registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // Window FSM next state; flush wins over a same-cycle sample, a pending push still lands.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    if (bus.flush) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            acc_d   = SW'(bus.in_data);
            cnt_d   = LOG2N'(1'b1);
            state_d = S_ACC;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ACC: begin
          if (bus.in_valid && (&cnt_q)) begin
            res_d   = DW'(sum_s >> LOG2N);
            state_d = S_PUSH;
          end else if (bus.in_valid) begin
            acc_d = sum_s;
            cnt_d = cnt_q + LOG2N'(1'b1);
          end else begin
            state_d = S_ACC;
          end
        end
        S_PUSH: begin
          if (bus.in_valid) begin
            acc_d   = SW'(bus.in_data);
            cnt_d   = LOG2N'(1'b1);
            state_d = S_ACC;
          end else begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign pop_s  = out_valid_q & bus.out_ready;
  assign push_s = (state_q == S_PUSH) && ((level_q != LW'(DEPTH)) || pop_s);
  assign drop_s = (state_q == S_PUSH) && !push_s;

  // FIFO occupancy, read pointer and the registered head seen on out_data.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LW'(1'b1);
      2'b01:   level_d = level_q - LW'(1'b1);
      default: level_d = level_q;
    endcase
    rd_ptr_d = pop_s ? (rd_ptr_q + AW'(1'b1)) : rd_ptr_q;
    // The new head is the incoming result when the FIFO is (or becomes) empty before the push.
    if (level_d == '0) begin
      out_data_d = out_data_q;
    end else if (push_s && (level_q == LW'(pop_s))) begin
      out_data_d = res_q;
    end else begin
      out_data_d = mem_q[rd_ptr_d];
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO storage, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= res_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1'b1);
      end
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= (level_d != '0);
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.ovf       = ovf_q;
  assign bus.level     = level_q;
endmodule

// File: tb/tb_iir_decimator.sv
// Directed bench for iir_decimator: a queue-based window/FIFO model checked every cycle,
// plus literal expectations for the hand-computed window averages and latencies.
module tb_iir_decimator;
  localparam int DW    = 12;
  localparam int LOG2N = 2;
  localparam int DEPTH = 4;
  localparam int NWIN  = 1 << LOG2N;

  logic clk;
  logic rst;
  int   nvec = 0;
  int   nerr = 0;

  iir_decimator_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

  iir_decimator #(.DW(DW), .LOG2N(LOG2N), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Model: samples collected per window, average pushed one cycle later into a bounded queue.
  int mq[$];
  int win[$];
  bit pend      = 1'b0;
  int pend_val  = 0;
  bit ovf_m     = 1'b0;
  int last_head = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      win.delete();
      pend      = 1'b0;
      pend_val  = 0;
      ovf_m     = 1'b0;
      last_head = 0;
    end else begin
      int  sz;
      int  s;
      bit  pop;
      bit  drop;
      sz   = mq.size();
      pop  = (sz != 0) && bus.out_ready;
      drop = 1'b0;
      if (pop) void'(mq.pop_front());
      if (pend) begin
        if (sz < DEPTH || pop) mq.push_back(pend_val);
        else drop = 1'b1;
      end
      if (drop) ovf_m = 1'b1;
      else if (bus.ovf_clr) ovf_m = 1'b0;
      pend = 1'b0;
      if (bus.flush) begin
        win.delete();
      end else if (bus.in_valid) begin
        win.push_back(int'(bus.in_data));
        if (win.size() == NWIN) begin
          s = 0;
          foreach (win[i]) s += win[i];
          pend_val = s >> LOG2N;
          pend     = 1'b1;
          win.delete();
        end
      end
      if (mq.size() != 0) last_head = mq[0];
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("out_valid", int'(bus.out_valid), int'(mq.size() != 0));
      chk("level", int'(bus.level), mq.size());
      chk("ovf", int'(bus.ovf), int'(ovf_m));
      chk("out_data", int'(bus.out_data), last_head);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic sample(input int d);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(d);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
  endtask

  task automatic window4(input int a, input int b, input int c, input int d);
    sample(a); idle(1);
    sample(b); idle(1);
    sample(c); idle(1);
    sample(d);
  endtask

  task automatic expect_pop(input string nm, input int exp);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.out_valid && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (!bus.out_valid) chk({nm, "_timeout"}, 0, 1);
    else chk(nm, int'(bus.out_data), exp);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.ovf_clr   = 1'b0;
    idle(2);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    rst = 1'b1;
    idle(1);

    // Reset mid-window with a result already queued.
    window4(7, 7, 7, 7);
    idle(3);
    chk("t1_pre_level", int'(bus.level), 1);
    sample(1);
    idle(1);
    sample(2);
    #2 rst = 1'b0;
    #1;
    chk("t1_async_valid", int'(bus.out_valid), 0);
    chk("t1_async_level", int'(bus.level), 0);
    chk("t1_async_ovf", int'(bus.ovf), 0);
    #1 rst = 1'b1;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    window4(1, 2, 3, 6);
    expect_pop("t1_clean", 3);

    // Latency of a single window: S_PUSH in t+1, out_valid in t+2.
    idle(2);
    window4(10, 20, 30, 41);
    #3 chk("t2_lat_t1", int'(bus.out_valid), 0);
    @(posedge clk);
    #3;
    chk("t2_lat_t2", int'(bus.out_valid), 1);
    chk("t2_data", int'(bus.out_data), 25);
    @(posedge clk);
    #2;
    chk("t2_popped", int'(bus.level), 0);

    // Full-scale and truncation.
    window4(4095, 4095, 4095, 4095);
    expect_pop("t3_max", 4095);
    window4(3, 3, 3, 3);
    expect_pop("t3_three", 3);
    window4(1, 1, 1, 2);
    expect_pop("t3_trunc", 1);

    // Overflow on a full FIFO, sticky flag and clear, in-order drain.
    bus.out_ready = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      window4(100 * w, 100 * w, 100 * w, 100 * w);
      idle(2);
    end
    idle(1);
    chk("t4_level", int'(bus.level), 4);
    chk("t4_ovf", int'(bus.ovf), 1);
    bus.ovf_clr = 1'b1;
    idle(1);
    bus.ovf_clr = 1'b0;
    chk("t4_ovf_clr", int'(bus.ovf), 0);
    bus.out_ready = 1'b1;
    expect_pop("t4_w1", 100);
    expect_pop("t4_w2", 200);
    expect_pop("t4_w3", 300);
    expect_pop("t4_w4", 400);
    chk("t4_empty", int'(bus.level), 0);

    // Push into a full FIFO on the same cycle as a pop: nothing dropped.
    bus.out_ready = 1'b0;
    for (int w = 1; w <= 4; w++) begin
      window4(11 * w, 11 * w, 11 * w, 11 * w);
      idle(2);
    end
    chk("t5_full", int'(bus.level), 4);
    window4(55, 55, 55, 55);
    bus.out_ready = 1'b1;
    idle(1);
    bus.out_ready = 1'b0;
    chk("t5_level", int'(bus.level), 4);
    chk("t5_ovf", int'(bus.ovf), 0);
    bus.out_ready = 1'b1;
    expect_pop("t5_w2", 22);
    expect_pop("t5_w3", 33);
    expect_pop("t5_w4", 44);
    expect_pop("t5_w5", 55);

    // Flush discards a partial window; back-to-back strobes through S_PUSH.
    sample(50);
    idle(1);
    sample(50);
    idle(1);
    bus.flush = 1'b1;
    idle(1);
    bus.flush = 1'b0;
    window4(8, 8, 8, 8);
    expect_pop("t6_flush", 8);
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'(i);
      @(posedge clk);
      #2;
    end
    bus.in_valid = 1'b0;
    idle(2);
    chk("t6_b2b_level", int'(bus.level), 2);
    bus.out_ready = 1'b1;
    expect_pop("t6_b2b_a", 2);
    expect_pop("t6_b2b_b", 6);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
